// File: rtl/ez8_loader_pkg.sv
// Shared constants for the EZ8 program loader: FSM state encoding, the default
// frame marker and the default program-size limit.
package ez8_loader_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_CNT_HI  = 3'd1;
  localparam state_t ST_CNT_LO  = 3'd2;
  localparam state_t ST_DATA_HI = 3'd3;
  localparam state_t ST_DATA_LO = 3'd4;
  localparam state_t ST_CSUM    = 3'd5;
  localparam state_t ST_DONE    = 3'd6;
  localparam state_t ST_ERR     = 3'd7;

  localparam logic [7:0]  DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int unsigned DEFAULT_ADDR_W    = 12;
  localparam int unsigned MAX_WORDS         = 32'd1 << DEFAULT_ADDR_W;

  // Largest word count a frame may carry for a memory of the given address width.
  function automatic int unsigned words_for(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/ez8_prog_loader.sv
// Byte-stream program loader: parses SYNC/COUNT/DATA/CSUM frames, writes each
// word to CPU instruction memory and holds the CPU in reset until a frame checks out.
module ez8_prog_loader
  import ez8_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W    = 16,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] instr_writeaddr,
  output logic [DATA_W-1:0] instr_writedata,
  output logic              instr_write_en,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error
);

  localparam int unsigned MAX_COUNT = words_for(ADDR_W);

  state_t              state_reg;
  logic                armed_reg;
  logic [7:0]          cnt_hi_reg;
  logic [15:0]         count_reg;
  logic [ADDR_W-1:0]   word_cnt_reg;
  logic [7:0]          data_hi_reg;
  logic [7:0]          csum_reg;

  logic                xfer;
  logic [15:0]         count_w;
  logic                count_bad;
  logic                last_word;
  logic [7:0]          csum_add;

  // armed_reg keeps rx_ready low while reset is held, rising on the first clock after.
  assign rx_ready  = armed_reg && (state_reg != ST_DONE) && (state_reg != ST_ERR);
  assign xfer      = rx_valid && rx_ready;
  assign count_w   = {cnt_hi_reg, rx_data};
  assign count_bad = (count_w == 16'd0) || (32'(count_w) > MAX_COUNT);
  assign last_word = ((32'(word_cnt_reg) + 32'd1) == 32'(count_reg));
  assign csum_add  = csum_reg + rx_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      armed_reg       <= 1'b0;
      cnt_hi_reg      <= '0;
      count_reg       <= '0;
      word_cnt_reg    <= '0;
      data_hi_reg     <= '0;
      csum_reg        <= '0;
      instr_writeaddr <= '0;
      instr_writedata <= '0;
      instr_write_en  <= 1'b0;
      cpu_reset       <= 1'b1;
      load_done       <= 1'b0;
      load_error      <= 1'b0;
    end else begin
      armed_reg      <= 1'b1;
      instr_write_en <= 1'b0;
      load_done      <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (xfer && (rx_data == SYNC_BYTE)) begin
            state_reg  <= ST_CNT_HI;
            load_error <= 1'b0;
            cpu_reset  <= 1'b1;
            csum_reg   <= '0;
          end
        end
        ST_CNT_HI: begin
          if (xfer) begin
            cnt_hi_reg <= rx_data;
            csum_reg   <= csum_add;
            state_reg  <= ST_CNT_LO;
          end
        end
        ST_CNT_LO: begin
          if (xfer) begin
            count_reg    <= count_w;
            csum_reg     <= csum_add;
            word_cnt_reg <= '0;
            if (count_bad) begin
              state_reg  <= ST_ERR;
              load_error <= 1'b1;
            end else begin
              state_reg  <= ST_DATA_HI;
            end
          end
        end
        ST_DATA_HI: begin
          if (xfer) begin
            data_hi_reg <= rx_data;
            csum_reg    <= csum_add;
            state_reg   <= ST_DATA_LO;
          end
        end
        ST_DATA_LO: begin
          if (xfer) begin
            instr_write_en  <= 1'b1;
            instr_writeaddr <= word_cnt_reg;
            instr_writedata <= DATA_W'({data_hi_reg, rx_data});
            csum_reg        <= csum_add;
            word_cnt_reg    <= word_cnt_reg + 1'b1;
            state_reg       <= last_word ? ST_CSUM : ST_DATA_HI;
          end
        end
        ST_CSUM: begin
          if (xfer) begin
            if (rx_data == csum_reg) begin
              state_reg <= ST_DONE;
              load_done <= 1'b1;
              cpu_reset <= 1'b0;
            end else begin
              state_reg  <= ST_ERR;
              load_error <= 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ez8_prog_loader.sv
// Randomized scoreboard bench for ez8_prog_loader: stimulus pushes expected writes
// and frame outcomes; an independent monitor pops and compares them.
module tb_ez8_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [11:0] instr_writeaddr;
  logic [15:0] instr_writedata;
  logic        instr_write_en;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;

  ez8_prog_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .instr_writeaddr(instr_writeaddr), .instr_writedata(instr_writedata),
    .instr_write_en(instr_write_en), .cpu_reset(cpu_reset),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [11:0] addr; logic [15:0] data; } wr_t;

  wr_t         exp_wr[$];
  bit          exp_out[$];   // 1 = frame accepted, 0 = frame rejected
  logic [7:0]  tx_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          no_gaps = 0;
  logic        err_prev = 1'b0;

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (instr_write_en) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got addr=%03h data=%04h, required no write", instr_writeaddr, instr_writedata);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          if (instr_writeaddr !== e.addr || instr_writedata !== e.data) begin
            errors++;
            $display("FAIL write: got addr=%03h data=%04h, required addr=%03h data=%04h",
                     instr_writeaddr, instr_writedata, e.addr, e.data);
          end else
            $display("write addr=%03h data=%04h ok", instr_writeaddr, instr_writedata);
        end
      end
      if (load_done || (load_error && !err_prev)) begin
        checks++;
        if (exp_out.size() == 0) begin
          errors++;
          $display("FAIL outcome_unexpected: got done=%0d error=%0d, required none", load_done, load_error);
        end else begin
          bit e;
          e = exp_out.pop_front();
          if (load_done !== e || cpu_reset !== !e) begin
            errors++;
            $display("FAIL outcome: got done=%0d cpu_reset=%0d, required done=%0d cpu_reset=%0d",
                     load_done, cpu_reset, e, !e);
          end else
            $display("frame outcome %s ok", e ? "done" : "error");
        end
      end
    end
    err_prev = load_error;
  end

  task automatic send_byte(input logic [7:0] b);
    int gap;
    int t;
    gap = (!no_gaps && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready) begin
      @(negedge clk);
      t++;
      if (t > 50) begin
        errors++;
        $display("FAIL rx_ready_timeout: got rx_ready=0 for 50 cycles, required 1");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "stalled");
      end
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic flush_tx();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
  endtask

  // Reference model: a frame of n words is accepted iff the trailing byte equals
  // the low 8 bits of the arithmetic sum of the count bytes and all data bytes.
  task automatic build_frame(input int n, input bit corrupt, input int n_garbage);
    int   sum;
    logic [7:0] g;
    logic [15:0] w;
    for (int i = 0; i < n_garbage; i++) begin
      do g = 8'($urandom); while (g == 8'hA5);
      tx_q.push_back(g);
    end
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'(n / 256));
    tx_q.push_back(8'(n % 256));
    sum = n / 256 + n % 256;
    if (n == 0 || n > 4096) begin
      exp_out.push_back(1'b0);
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 7) == 0) w[15:8] = 8'hA5;
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[7:0]);
      sum += w[15:8] + w[7:0];
      exp_wr.push_back('{addr: 12'(i), data: w});
    end
    if (corrupt) tx_q.push_back(8'(sum % 256) ^ 8'($urandom_range(1, 255)));
    else         tx_q.push_back(8'(sum % 256));
    exp_out.push_back(!corrupt);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end else
      $display("%s = %0h ok", name, got);
  endtask

  task automatic push_ref_frame(input logic [7:0] csum);
    logic [7:0] f[8];
    f = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, csum};
    for (int i = 0; i < 8; i++) tx_q.push_back(f[i]);
    exp_wr.push_back('{addr: 12'h000, data: 16'h1234});
    exp_wr.push_back('{addr: 12'h001, data: 16'h5678});
    exp_out.push_back(csum == 8'h16);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_wr.size() != 0 || exp_out.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_pending_writes"}, 32'(exp_wr.size()), 32'd0);
    chk({name, "_pending_outcomes"}, 32'(exp_out.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({name, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({name, "_write_en"}, 32'(instr_write_en), 32'd0);
    chk({name, "_writeaddr"}, 32'(instr_writeaddr), 32'd0);
    chk({name, "_writedata"}, 32'(instr_writedata), 32'd0);
    chk({name, "_load_done"}, 32'(load_done), 32'd0);
    chk({name, "_load_error"}, 32'(load_error), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_reset", 32'(rx_ready), 32'd1);

    // Reference frame, good checksum.
    push_ref_frame(8'h16); flush_tx(); drain("good_frame");
    chk("cpu_reset_after_done", 32'(cpu_reset), 32'd0);

    // Same frame, wrong checksum: writes happen, frame rejected.
    push_ref_frame(8'h17); flush_tx(); drain("bad_csum");
    chk("load_error_sticky", 32'(load_error), 32'd1);
    chk("cpu_reset_after_err", 32'(cpu_reset), 32'd1);

    // Leading junk ignored.
    tx_q.push_back(8'h00); tx_q.push_back(8'hFF); tx_q.push_back(8'h3C);
    push_ref_frame(8'h16); flush_tx(); drain("leading_junk");
    chk("load_error_cleared", 32'(load_error), 32'd0);

    // Count out of range.
    build_frame(0, 0, 0); flush_tx(); drain("count_zero");
    build_frame(16'h1001, 0, 0); flush_tx(); drain("count_4097");
    chk("count_4097_error", 32'(load_error), 32'd1);

    // Randomized frames.
    for (int k = 0; k < 30; k++) begin
      build_frame($urandom_range(1, 8), $urandom_range(0, 3) == 0, $urandom_range(0, 3));
      flush_tx();
    end
    drain("random");

    // Full-size program.
    no_gaps = 1;
    build_frame(4096, 0, 0); flush_tx(); drain("max_frame");
    no_gaps = 0;

    // Reset mid-frame after the first word, then a clean reload.
    tx_q.push_back(8'hA5); tx_q.push_back(8'h00); tx_q.push_back(8'h02);
    tx_q.push_back(8'h12); tx_q.push_back(8'h34);
    exp_wr.push_back('{addr: 12'h000, data: 16'h1234});
    flush_tx();
    repeat (2) @(negedge clk);
    chk("midframe_write_seen", 32'(exp_wr.size()), 32'd0);
    reset = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rx_ready_after_reset2", 32'(rx_ready), 32'd1);
    push_ref_frame(8'h16); flush_tx(); drain("reload");
    chk("cpu_reset_after_reload", 32'(cpu_reset), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ez8_prog_loader.md
EZ8_PROG_LOADER -- requirements
Module: ez8_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, instruction-memory word address width.
REQ-002 SHALL have parameter DATA_W, default 16, instruction word width; fixed at two bytes.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port rx_data  input  8  incoming byte stream.
REQ-007 SHALL have port rx_valid  input  1  rx_data valid.
REQ-008 SHALL have port rx_ready  output  1  loader accepts byte; transfer when rx_valid && rx_ready.
REQ-009 SHALL have port instr_writeaddr  output  ADDR_W  CPU instruction-memory write address.
REQ-010 SHALL have port instr_writedata  output  DATA_W  CPU instruction-memory write data.
REQ-011 SHALL have port instr_write_en  output  1  one-cycle write strobe.
REQ-012 SHALL have port cpu_reset  output  1  holds CPU in reset while no valid program is loaded.
REQ-013 SHALL have port load_done  output  1  one-cycle pulse on successful frame.
REQ-014 SHALL have port load_error  output  1  sticky frame-error flag.

Function
REQ-015 SHALL parse frame: SYNC_BYTE, COUNT_HI, COUNT_LO, then COUNT words each sent high byte then low byte, then CSUM.
REQ-016 SHALL use FSM states IDLE, CNT_HI, CNT_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR.
REQ-017 SHALL in IDLE discard every accepted byte other than SYNC_BYTE; SYNC_BYTE -> CNT_HI, clears load_error, asserts cpu_reset the next cycle.
REQ-018 SHALL after CNT_LO go to ERR when COUNT == 0 or COUNT > 2**ADDR_W, else DATA_HI with word address counter = 0.
REQ-019 SHALL on accepted DATA_LO byte drive, registered one cycle later, instr_write_en=1, instr_writeaddr=counter, instr_writedata={hi,lo}; instr_write_en low in all other cycles.
REQ-020 SHALL increment address counter per word; after word COUNT-1 go to CSUM, else DATA_HI; counter wrap at 2**ADDR_W is unreachable by REQ-018.
REQ-021 SHALL compute CSUM as mod-256 sum of COUNT_HI, COUNT_LO and all data bytes; SYNC_BYTE and CSUM excluded.
REQ-022 SHALL on CSUM match go to DONE: load_done pulses 1 cycle, cpu_reset deasserts the same cycle and stays low until the next SYNC_BYTE or reset.
REQ-023 SHALL on CSUM mismatch go to ERR: load_error=1 (sticky), cpu_reset stays 1; memory writes already issued are not rolled back.
REQ-024 SHALL keep DONE and ERR one cycle each with rx_ready=0, then return to IDLE.
REQ-025 SHALL drive rx_ready=1 in IDLE through CSUM; no other backpressure.
REQ-026 SHALL treat SYNC_BYTE appearing mid-frame as ordinary data/count/checksum byte.

Reset
REQ-027 SHALL on reset asynchronously force FSM=IDLE, counters and checksum=0, instr_writeaddr=0, instr_writedata=0, instr_write_en=0, load_done=0, load_error=0, rx_ready=0, cpu_reset=1.
REQ-028 SHALL let reset dominate any simultaneous transfer; a frame interrupted by reset is abandoned, and no write strobe issues from the abandoned byte.
REQ-029 SHALL assert rx_ready the first clock after reset deasserts.

Structure
REQ-030 SHALL place FSM state enum, SYNC_BYTE default and MAX_WORDS constant in shared package ez8_loader_pkg.
REQ-031 SHALL be a single module; no sub-module; output drives the CPU write port directly.

Verification
REQ-032 SHALL cover: A5 00 02 12 34 56 78 16 -> writes (0x000,0x1234),(0x001,0x5678), load_done pulse, cpu_reset 1->0.
REQ-033 SHALL cover: same frame with CSUM 17 -> both writes occur, load_error=1, cpu_reset stays 1, no load_done.
REQ-034 SHALL cover: 00 FF 3C then valid frame from REQ-032 -> leading bytes ignored, identical result.
REQ-035 SHALL cover: A5 00 00 -> ERR after COUNT_LO, load_error=1; A5 10 01 -> error likewise, no writes.
REQ-036 SHALL cover: A5 10 00 + 4096 words + correct CSUM -> 4096 strobes, last instr_writeaddr=0xFFF, load_done.
REQ-037 SHALL cover: reset asserted after first word of REQ-032 frame -> all outputs at reset values, then a full frame loads correctly.
